// File: rtl/sd_data_crc16_calc.sv
// Four-lane CRC-16/CCITT (poly 0x1021, init 0, MSB first) engine for SD 4-bit DAT read data.
// Bit-serial by default; define SD_CRC_PARALLEL_EN to fold a whole byte per lane on the strobe edge.
module sd_data_crc16_calc #(
  parameter int DATA_STRING = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CRC_En,
  input  logic        CRC_Data_Get,
  input  logic [7:0]  Temp_Byte_0,
  input  logic [7:0]  Temp_Byte_1,
  input  logic [7:0]  Temp_Byte_2,
  input  logic [7:0]  Temp_Byte_3,
  output logic [15:0] CRC_0,
  output logic [15:0] CRC_1,
  output logic [15:0] CRC_2,
  output logic [15:0] CRC_3,
  output logic        CRC_Valid,
  output logic        CRC_Overrun
);

  localparam int CNT_W = $clog2(DATA_STRING) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_STRING - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0][15:0] crc_q, crc_d;
  logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             dataGet_q;
  logic             strobe;
  logic             lastByte;
  logic [3:0][7:0]  tempByte;
`ifndef SD_CRC_PARALLEL_EN
  logic [3:0][7:0]  sh_q, sh_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
`endif

  function automatic logic [15:0] crcBit(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
  endfunction

`ifdef SD_CRC_PARALLEL_EN
  function automatic logic [15:0] crcByte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = crcBit(c, din[i]);
    end
    return c;
  endfunction
`endif

  assign tempByte = {Temp_Byte_3, Temp_Byte_2, Temp_Byte_1, Temp_Byte_0};
  // Edge-detect so a level-held CRC_Data_Get contributes exactly one byte.
  assign strobe   = CRC_Data_Get & ~dataGet_q;
  assign lastByte = (byteCnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!CRC_En) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT_BYTE: begin
          state_d = S_WAIT_BYTE;
          if (strobe) begin
`ifdef SD_CRC_PARALLEL_EN
            state_d = lastByte ? S_DONE : S_WAIT_BYTE;
`else
            state_d = S_SHIFT;
`endif
          end
        end
`ifndef SD_CRC_PARALLEL_EN
        S_SHIFT: begin
          if (bitCnt_q == 3'd7) begin
            state_d = lastByte ? S_DONE : S_WAIT_BYTE;
          end
        end
`endif
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A low CRC_En wipes every lane so an aborted block leaves no residue.
  always_comb begin
    crc_d     = crc_q;
    byteCnt_d = byteCnt_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifndef SD_CRC_PARALLEL_EN
    sh_d      = sh_q;
    bitCnt_d  = bitCnt_q;
`endif
    if (!CRC_En) begin
      crc_d     = '0;
      byteCnt_d = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
`ifndef SD_CRC_PARALLEL_EN
      sh_d      = '0;
      bitCnt_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_WAIT_BYTE: begin
          if (strobe) begin
`ifdef SD_CRC_PARALLEL_EN
            for (int l = 0; l < 4; l++) begin
              crc_d[l] = crcByte(crc_q[l], tempByte[l]);
            end
            if (lastByte) begin
              valid_d = 1'b1;
            end else begin
              byteCnt_d = byteCnt_q + CNT_W'(1);
            end
`else
            sh_d     = tempByte;
            bitCnt_d = '0;
`endif
          end
        end
`ifndef SD_CRC_PARALLEL_EN
        S_SHIFT: begin
          for (int l = 0; l < 4; l++) begin
            crc_d[l] = crcBit(crc_q[l], sh_q[l][7]);
            sh_d[l]  = {sh_q[l][6:0], 1'b0};
          end
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            if (lastByte) begin
              valid_d = 1'b1;
            end else begin
              byteCnt_d = byteCnt_q + CNT_W'(1);
            end
          end
          if (strobe) begin
            overrun_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= '0;
      byteCnt_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      dataGet_q <= 1'b0;
`ifndef SD_CRC_PARALLEL_EN
      sh_q      <= '0;
      bitCnt_q  <= '0;
`endif
    end else begin
      crc_q     <= crc_d;
      byteCnt_q <= byteCnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      dataGet_q <= CRC_Data_Get;
`ifndef SD_CRC_PARALLEL_EN
      sh_q      <= sh_d;
      bitCnt_q  <= bitCnt_d;
`endif
    end
  end

  always_comb begin
    CRC_0       = crc_q[0];
    CRC_1       = crc_q[1];
    CRC_2       = crc_q[2];
    CRC_3       = crc_q[3];
    CRC_Valid   = valid_q;
    CRC_Overrun = overrun_q;
  end

endmodule

// File: tb/tb_sd_data_crc16_calc.sv
// Self-checking bench for sd_data_crc16_calc: byte-level CRC reference model plus
// literal expectations for the "123456789" check value; adapts to SD_CRC_PARALLEL_EN.
module tb_sd_data_crc16_calc;

  localparam int DS = 9;
`ifdef SD_CRC_PARALLEL_EN
  localparam bit PAR = 1'b1;
  localparam int SP  = 8;
`else
  localparam bit PAR = 1'b0;
  localparam int SP  = 10;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            CRC_En;
  logic            CRC_Data_Get;
  logic [3:0][7:0] tByte;
  logic [3:0][15:0] dutCrc;
  logic            CRC_Valid;
  logic            CRC_Overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_data_crc16_calc #(.DATA_STRING(DS)) dut (
    .clk          (clk),
    .rst          (rst),
    .CRC_En       (CRC_En),
    .CRC_Data_Get (CRC_Data_Get),
    .Temp_Byte_0  (tByte[0]),
    .Temp_Byte_1  (tByte[1]),
    .Temp_Byte_2  (tByte[2]),
    .Temp_Byte_3  (tByte[3]),
    .CRC_0        (dutCrc[0]),
    .CRC_1        (dutCrc[1]),
    .CRC_2        (dutCrc[2]),
    .CRC_3        (dutCrc[3]),
    .CRC_Valid    (CRC_Valid),
    .CRC_Overrun  (CRC_Overrun)
  );

  // Reference model: accepted bytes per lane, fold busy time, sticky flags.
  logic [7:0] accB [4][DS];
  int nAcc = 0;
  int busy = 0;
  bit mValid = 1'b0;
  bit mOverrun = 1'b0;
  bit prevGet = 1'b0;
  bit ready = 1'b0;

  function automatic logic [15:0] refCrc(input int lane);
    int unsigned r;
    r = 0;
    for (int i = 0; i < nAcc; i++) begin
      r = r ^ (32'(accB[lane][i]) << 8);
      for (int k = 0; k < 8; k++) begin
        r = ((r & 32'h8000) != 0) ? ((r << 1) ^ 32'h1021) : (r << 1);
      end
      r = r & 32'hFFFF;
    end
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each active edge from the inputs the DUT sampled.
  always @(posedge clk) begin : model
    bit strobe;
    strobe = CRC_Data_Get && !prevGet;
    ready  = 1'b1;
    if (rst || !CRC_En) begin
      nAcc = 0; busy = 0; mValid = 1'b0; mOverrun = 1'b0;
    end else if (busy > 0) begin
      if (strobe) mOverrun = 1'b1;
      busy--;
      if (busy == 0 && nAcc == DS) mValid = 1'b1;
    end else if (!mValid && strobe) begin
      for (int l = 0; l < 4; l++) accB[l][nAcc] = tByte[l];
      nAcc++;
      if (PAR) begin
        if (nAcc == DS) mValid = 1'b1;
      end else begin
        busy = 8;
      end
    end
    prevGet = rst ? 1'b0 : CRC_Data_Get;
  end

  // Compare on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (ready) begin
      checkOutput("valid", {15'b0, CRC_Valid}, {15'b0, mValid});
      checkOutput("overrun", {15'b0, CRC_Overrun}, {15'b0, mOverrun});
      if (busy == 0) begin
        for (int l = 0; l < 4; l++) begin
          checkOutput($sformatf("crc_lane%0d", l), dutCrc[l], refCrc(l));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input int hold, input int gap);
    tByte[0] = b0; tByte[1] = b1; tByte[2] = b2; tByte[3] = b3;
    CRC_Data_Get = 1'b1;
    repeat (hold) @(negedge clk);
    CRC_Data_Get = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendStream();
    for (int i = 0; i < DS; i++) begin
      applyStimulus(8'(8'h31 + i), 8'h00, 8'h00, 8'h00, 1, SP - 1);
    end
  endtask

  task automatic clearEngine();
    CRC_Data_Get = 1'b0;
    CRC_En = 1'b0;
    @(negedge clk);
    CRC_En = 1'b1;
  endtask

  task automatic checkCheckValue(input string tag);
    checkOutput({tag, "_crc0"}, dutCrc[0], 16'h31C3);
    checkOutput({tag, "_crc1"}, dutCrc[1], 16'h0000);
    checkOutput({tag, "_crc2"}, dutCrc[2], 16'h0000);
    checkOutput({tag, "_crc3"}, dutCrc[3], 16'h0000);
    checkOutput({tag, "_valid"}, {15'b0, CRC_Valid}, 16'h0001);
  endtask

  initial begin
    rst = 1'b1; CRC_En = 1'b0; CRC_Data_Get = 1'b0; tByte = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_crc0", dutCrc[0], 16'h0000);
    checkOutput("reset_valid", {15'b0, CRC_Valid}, 16'h0000);
    checkOutput("reset_overrun", {15'b0, CRC_Overrun}, 16'h0000);
    rst = 1'b0;

    // Check string with byte 0 strobed in the same cycle CRC_En rises.
    CRC_En = 1'b1;
    sendStream();
    checkCheckValue("s1");
    checkOutput("s1_overrun", {15'b0, CRC_Overrun}, 16'h0000);
    checkOutput("model_pin", refCrc(0), 16'h31C3);

    // Strobes and zeroed bytes after completion must not disturb the result.
    tByte = '1;
    CRC_Data_Get = 1'b1;
    repeat (16) @(negedge clk);
    tByte = '0;
    CRC_Data_Get = 1'b0;
    repeat (2) @(negedge clk);
    CRC_Data_Get = 1'b1;
    repeat (4) @(negedge clk);
    checkCheckValue("s2_hold");

    CRC_Data_Get = 1'b0;
    CRC_En = 1'b0;
    @(negedge clk);
    checkOutput("s5_clr_crc0", dutCrc[0], 16'h0000);
    checkOutput("s5_clr_valid", {15'b0, CRC_Valid}, 16'h0000);

    // Abort after 4 bytes, then a complete block.
    CRC_En = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'hA0, 8'h11, 8'h22, 8'h33, 1, SP - 1);
    clearEngine();
    sendStream();
    checkCheckValue("s3_abort");

    // Reset in the middle of a byte fold.
    clearEngine();
    for (int i = 0; i < 3; i++) applyStimulus(8'hC3, 8'h3C, 8'h96, 8'h69, 1, SP - 1);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sendStream();
    checkCheckValue("s3_rst");

    // Two strobes four cycles apart.
    clearEngine();
    applyStimulus(8'hA5, 8'h5A, 8'h0F, 8'hF0, 1, 3);
    applyStimulus(8'h5A, 8'hA5, 8'hF0, 8'h0F, 1, SP);
    checkOutput("s4_overrun", {15'b0, CRC_Overrun}, PAR ? 16'h0000 : 16'h0001);
    for (int i = 0; i < DS; i++) applyStimulus(8'(i * 7), 8'(i * 13), 8'(i * 29), 8'(i * 31), 1, SP - 1);
    checkOutput("s4_overrun_sticky", {15'b0, CRC_Overrun}, PAR ? 16'h0000 : 16'h0001);
    CRC_En = 1'b0;
    @(negedge clk);
    checkOutput("s4_overrun_clr", {15'b0, CRC_Overrun}, 16'h0000);

    // Level-held strobe counts once.
    CRC_En = 1'b1;
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 20, 10);

    // Randomised blocks with occasional aborts.
    for (int b = 0; b < 25; b++) begin
      int nb;
      int abortAt;
      clearEngine();
      nb = int'($urandom_range(9, 13));
      abortAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 99;
      for (int i = 0; i < nb; i++) begin
        if (i == abortAt) clearEngine();
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(1, 3)),
                      PAR ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 12)));
      end
      repeat (12) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
